// File: rtl/bp_me_pkg.sv
// BlackParrot memory-message types used by the Wishbone bridge: configuration
// selector, uncached command opcodes, access sizes and the CCE memory message.
package bp_me_pkg;

    typedef enum logic [3:0] {
        e_bp_default_cfg     = 4'd0,
        e_bp_single_core_cfg = 4'd1
    } bp_params_e;

    localparam int paddr_width_gp     = 40;
    localparam int cce_block_width_gp = 512;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'b0000,
        e_cce_mem_wr    = 4'b0001,
        e_cce_mem_uc_rd = 4'b0010,
        e_cce_mem_uc_wr = 4'b0011,
        e_cce_mem_pre   = 4'b0100
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [2:0] {
        e_mem_size_1  = 3'b000,
        e_mem_size_2  = 3'b001,
        e_mem_size_4  = 3'b010,
        e_mem_size_8  = 3'b011,
        e_mem_size_16 = 3'b100,
        e_mem_size_32 = 3'b101,
        e_mem_size_64 = 3'b110
    } bp_mem_size_e;

    typedef struct packed {
        logic [cce_block_width_gp-1:0] data;
        logic [15:0]                   payload;
        bp_mem_size_e                  size;
        logic [paddr_width_gp-1:0]     addr;
        bp_cce_mem_cmd_type_e          msg_type;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_msg_width_gp = $bits(bp_cce_mem_msg_s);

endpackage

// File: rtl/wb2bp_pkg.sv
// Shared types for the Wishbone-to-BP bridge: FSM states and the byte-select
// decode result. The DRAIN state exists only when WB2BP_TIMEOUT_EN is defined.
package wb2bp_pkg;

    import bp_me_pkg::*;

    localparam int wb2bp_word_bytes_lp = 8;
    localparam int wb2bp_off_width_lp  = $clog2(wb2bp_word_bytes_lp);

    typedef enum logic [2:0] {
        e_idle,
        e_send,
        e_wait,
        e_ack,
        e_err
`ifdef WB2BP_TIMEOUT_EN
        , e_drain
`endif
    } wb2bp_state_e;

    typedef struct packed {
        logic                          legal;
        bp_mem_size_e                  size;
        logic [wb2bp_off_width_lp-1:0] off;
    } wb2bp_sel_decode_s;

endpackage

// File: rtl/wb2bp_sel_decode.sv
// Maps a Wishbone byte-select mask to a BP access size and byte offset.
// Only contiguous, naturally aligned masks are legal; all-zero is illegal.
module wb2bp_sel_decode
    import bp_me_pkg::*;
    import wb2bp_pkg::*;
(
    input  logic [wb2bp_word_bytes_lp-1:0]        sel,
    output logic [$bits(wb2bp_sel_decode_s)-1:0]  decode
);

    logic [7:0] hit1;
    logic [3:0] hit2;
    logic [1:0] hit4;
    logic       hit8;
    wb2bp_sel_decode_s result;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_b1
            assign hit1[gi] = (sel == (8'h01 << gi));
        end
        for (gi = 0; gi < 4; gi++) begin : g_b2
            assign hit2[gi] = (sel == (8'h03 << (2 * gi)));
        end
        for (gi = 0; gi < 2; gi++) begin : g_b4
            assign hit4[gi] = (sel == (8'h0F << (4 * gi)));
        end
    endgenerate
    assign hit8 = (sel == 8'hFF);

    // At most one hit is set, since each pattern is a distinct mask value.
    always_comb begin
        result = '0;
        for (int i = 0; i < 8; i++) begin
            if (hit1[i]) begin
                result.legal = 1'b1;
                result.size  = e_mem_size_1;
                result.off   = 3'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (hit2[i]) begin
                result.legal = 1'b1;
                result.size  = e_mem_size_2;
                result.off   = 3'(2 * i);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (hit4[i]) begin
                result.legal = 1'b1;
                result.size  = e_mem_size_4;
                result.off   = 3'(4 * i);
            end
        end
        if (hit8) begin
            result.legal = 1'b1;
            result.size  = e_mem_size_8;
            result.off   = 3'd0;
        end
    end

    assign decode = result;

endmodule

// File: rtl/wb2bp_convertor.sv
// Wishbone classic slave turning each single access into one uncached BP memory
// command. Define WB2BP_TIMEOUT_EN to add the WAIT watchdog and DRAIN state.
module wb2bp_convertor
    import bp_me_pkg::*;
    import wb2bp_pkg::*;
#(
    parameter bp_params_e bp_params_p         = e_bp_single_core_cfg,
    parameter int         timeout_cycles_p    = 1024,
    localparam int        paddr_width_p       = paddr_width_gp,
    localparam int        cce_mem_msg_width_lp = cce_mem_msg_width_gp
)(
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [paddr_width_p-4:0]        adr_i,
    input  logic [63:0]                     dat_i,
    output logic [63:0]                     dat_o,
    input  logic [7:0]                      sel_i,
    input  logic                            we_i,
    input  logic                            stb_i,
    input  logic                            cyc_i,
    input  logic [2:0]                      cti_i,
    input  logic [1:0]                      bte_i,
    output logic                            ack_o,
    output logic                            err_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o,
    output logic                            mem_cmd_v_o,
    input  logic                            mem_cmd_ready_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i,
    input  logic                            mem_resp_v_i,
    output logic                            mem_resp_yumi_o
);

    localparam bit unused_cfg_lp = (bp_params_p == e_bp_single_core_cfg);

    wb2bp_state_e      state_reg, state_next;
    bp_cce_mem_msg_s   cmd_reg, cmd_load, resp;
    wb2bp_sel_decode_s decode;
    logic [$bits(wb2bp_sel_decode_s)-1:0] decode_bits;
    logic [2:0]        off_reg;
    logic [63:0]       dat_reg;
    logic              ack_reg, ack_next, err_reg, err_next, accept, timeout;
    logic              unused;

    wb2bp_sel_decode sel_decode (
        .sel    (sel_i),
        .decode (decode_bits)
    );

    assign decode = decode_bits;
    assign resp   = mem_resp_i;
    assign unused = ^{cti_i, bte_i, resp.data[cce_block_width_gp-1:64], resp.payload,
                      resp.size, resp.addr, resp.msg_type, unused_cfg_lp};

`ifdef WB2BP_TIMEOUT_EN
    localparam int timer_width_lp = $clog2(timeout_cycles_p + 1);
    localparam logic [timer_width_lp-1:0] timer_last_lp = timer_width_lp'(timeout_cycles_p - 1);
    logic [timer_width_lp-1:0] timer_reg;

    // Counts WAIT cycles; restarts from zero every time WAIT is entered.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            timer_reg <= '0;
        end else if (state_reg == e_wait) begin
            timer_reg <= timer_reg + timer_width_lp'(1);
        end else begin
            timer_reg <= '0;
        end
    end

    assign timeout = (state_reg == e_wait) && (timer_reg == timer_last_lp);
`else
    localparam int unused_timeout_lp = timeout_cycles_p;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next       = state_reg;
        mem_cmd_v_o      = 1'b0;
        mem_resp_yumi_o  = 1'b0;
        accept           = 1'b0;
        cmd_load         = '0;
        cmd_load.addr    = {adr_i, decode.off};
        cmd_load.msg_type = we_i ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
        cmd_load.size    = decode.size;
        cmd_load.data[63:0] = dat_i >> {decode.off, 3'b000};

        case (state_reg)
            e_idle: begin
                if (cyc_i && stb_i) begin
                    if (decode.legal) begin
                        accept     = 1'b1;
                        state_next = e_send;
                    end else begin
                        state_next = e_err;
                    end
                end
            end
            e_send: begin
                mem_cmd_v_o = 1'b1;
                if (mem_cmd_ready_i) begin
                    state_next = e_wait;
                end
            end
            e_wait: begin
                mem_resp_yumi_o = mem_resp_v_i;
                if (mem_resp_v_i) begin
                    state_next = e_ack;
                end
`ifdef WB2BP_TIMEOUT_EN
                else if (timeout) begin
                    state_next = e_drain;
                end
`endif
            end
            e_ack, e_err: state_next = e_idle;
`ifdef WB2BP_TIMEOUT_EN
            e_drain: begin
                mem_resp_yumi_o = mem_resp_v_i;
                if (mem_resp_v_i) begin
                    state_next = e_idle;
                end
            end
`endif
            default: state_next = e_idle;
        endcase

        // A response arriving on the watchdog's last cycle wins over the timeout.
        ack_next = (state_next == e_ack) && cyc_i;
        err_next = ((state_next == e_err) || (timeout && !mem_resp_v_i)) && cyc_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= e_idle;
            cmd_reg   <= '0;
            off_reg   <= '0;
            dat_reg   <= '0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
            if (accept) begin
                cmd_reg <= cmd_load;
                off_reg <= decode.off;
            end
            if ((state_reg == e_wait) && mem_resp_v_i && (cmd_reg.msg_type == e_cce_mem_uc_rd)) begin
                dat_reg <= resp.data[63:0] << {off_reg, 3'b000};
            end
        end
    end

    assign mem_cmd_o = cmd_reg;
    assign dat_o     = dat_reg;
    assign ack_o     = ack_reg;
    assign err_o     = err_reg;

endmodule

// File: tb/tb_wb2bp_convertor.sv
// Directed bench for wb2bp_convertor; the watchdog scenario runs only when
// WB2BP_TIMEOUT_EN is defined.
module tb_wb2bp_convertor;
    import bp_me_pkg::*;

    localparam int msg_w = cce_mem_msg_width_gp;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [36:0]      adr;
    logic [63:0]      dat_w, dat_r;
    logic [7:0]       sel;
    logic             we, stb, cyc;
    logic [2:0]       cti;
    logic [1:0]       bte;
    logic             ack, err;
    logic [msg_w-1:0] mem_cmd, mem_resp;
    logic             mem_cmd_v, mem_cmd_ready, mem_resp_v, mem_resp_yumi;

    int n_checks = 0;
    int n_fail   = 0;

    bp_cce_mem_msg_s cap_cmd;
    int  n_ack, n_err, n_cmdv, n_yumi, ack_lat, err_lat;
    bit  cap_stable, timed_out;

    always #5 clk = ~clk;

    wb2bp_convertor #(.timeout_cycles_p(16)) dut (
        .clk_i           (clk),
        .reset_i         (rst),
        .adr_i           (adr),
        .dat_i           (dat_w),
        .dat_o           (dat_r),
        .sel_i           (sel),
        .we_i            (we),
        .stb_i           (stb),
        .cyc_i           (cyc),
        .cti_i           (cti),
        .bte_i           (bte),
        .ack_o           (ack),
        .err_o           (err),
        .mem_cmd_o       (mem_cmd),
        .mem_cmd_v_o     (mem_cmd_v),
        .mem_cmd_ready_i (mem_cmd_ready),
        .mem_resp_i      (mem_resp),
        .mem_resp_v_i    (mem_resp_v),
        .mem_resp_yumi_o (mem_resp_yumi)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One Wishbone access with a scripted BP side; records what was observed.
    task automatic run_access(input logic wr, input logic [36:0] a, input logic [7:0] s,
                              input logic [63:0] wdata, input logic [63:0] rdata,
                              input int ready_delay, input int resp_delay, input bit drop_cyc);
        bit cmd_done = 0, resp_done = 0, hs_cmd = 0, hs_resp = 0;
        int wait_cycles = 0, tail = -1;
        bp_cce_mem_msg_s r;
        n_ack = 0; n_err = 0; n_cmdv = 0; n_yumi = 0; ack_lat = -1; err_lat = -1;
        cap_stable = 1; cap_cmd = '0;
        r = '0;
        r.msg_type = e_cce_mem_uc_rd;
        r.data[63:0] = rdata;
        r.data[127:64] = '1;
        we = wr; adr = a; sel = s; dat_w = wdata; cyc = 1'b1; stb = 1'b1;
        mem_cmd_ready = 1'b0; mem_resp_v = 1'b0;
        for (int t = 1; t <= 300 && tail != 0; t++) begin
            @(posedge clk); #1;
            if (hs_cmd) cmd_done = 1;
            if (hs_resp) begin resp_done = 1; mem_resp_v = 1'b0; end
            if (ack) begin n_ack++; if (ack_lat < 0) ack_lat = t; end
            if (err) begin n_err++; if (err_lat < 0) err_lat = t; end
            if (mem_cmd_v) begin
                n_cmdv++;
                if (n_cmdv == 1) cap_cmd = mem_cmd;
                else if (mem_cmd !== cap_cmd) cap_stable = 0;
            end
            mem_cmd_ready = mem_cmd_v && (n_cmdv > ready_delay);
            if (cmd_done && !resp_done) begin
                wait_cycles++;
                if (drop_cyc) begin cyc = 1'b0; stb = 1'b0; end
                if (wait_cycles > resp_delay) begin mem_resp = r; mem_resp_v = 1'b1; end
            end
            if (ack || err) begin cyc = 1'b0; stb = 1'b0; end
            if (tail < 0) begin
                if (resp_done || (err && !cmd_done)) tail = 3;
            end else begin
                tail--;
            end
            #1;
            hs_cmd  = mem_cmd_v && mem_cmd_ready;
            hs_resp = mem_resp_v && mem_resp_yumi;
            if (mem_resp_yumi) n_yumi++;
        end
        timed_out = (tail != 0);
        cyc = 1'b0; stb = 1'b0; mem_cmd_ready = 1'b0; mem_resp_v = 1'b0;
    endtask

    initial begin
        adr = '0; dat_w = '0; sel = '0; we = 0; stb = 0; cyc = 0; cti = '0; bte = '0;
        mem_cmd_ready = 0; mem_resp = '0; mem_resp_v = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 64'(ack), 0);
        check("rst_err", 64'(err), 0);
        check("rst_cmd_v", 64'(mem_cmd_v), 0);
        check("rst_yumi", 64'(mem_resp_yumi), 0);
        check("rst_dat_o", dat_r, 0);
        check("rst_cmd_zero", 64'(|mem_cmd), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        mem_resp_v = 1'b1; #1;
        check("idle_no_yumi", 64'(mem_resp_yumi), 0);
        mem_resp_v = 1'b0;
        @(posedge clk); #1;

        // 8-byte read
        run_access(1'b0, 37'h0200_0000, 8'hFF, 64'h0, 64'hDEAD_BEEF_0123_4567, 0, 0, 0);
        $display("rd8  addr=%0h size=%0d ack_lat=%0d dat_o=%h", cap_cmd.addr, cap_cmd.size, ack_lat, dat_r);
        check("rd8_done", 64'(timed_out), 0);
        check("rd8_addr", 64'(cap_cmd.addr), 64'h1000_0000);
        check("rd8_size", 64'(cap_cmd.size), 64'(e_mem_size_8));
        check("rd8_type", 64'(cap_cmd.msg_type), 64'(e_cce_mem_uc_rd));
        check("rd8_payload", 64'(cap_cmd.payload), 0);
        check("rd8_dat_o", dat_r, 64'hDEAD_BEEF_0123_4567);
        check("rd8_ack_lat", 64'(ack_lat), 3);
        check("rd8_n_ack", 64'(n_ack), 1);
        check("rd8_n_yumi", 64'(n_yumi), 1);

        // byte write, lane 5
        run_access(1'b1, 37'h40, 8'h20, 64'h0000_AB00_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        $display("wr1  addr=%0h size=%0d data=%h n_ack=%0d", cap_cmd.addr, cap_cmd.size, cap_cmd.data[63:0], n_ack);
        check("wr1_done", 64'(timed_out), 0);
        check("wr1_addr", 64'(cap_cmd.addr), 64'h205);
        check("wr1_size", 64'(cap_cmd.size), 64'(e_mem_size_1));
        check("wr1_type", 64'(cap_cmd.msg_type), 64'(e_cce_mem_uc_wr));
        check("wr1_data", cap_cmd.data[63:0], 64'hAB);
        check("wr1_n_ack", 64'(n_ack), 1);
        check("wr1_dat_o_hold", dat_r, 64'hDEAD_BEEF_0123_4567);

        // illegal masks
        run_access(1'b0, 37'h8, 8'h05, 64'h0, 64'h0, 0, 0, 0);
        $display("sel05 n_err=%0d err_lat=%0d n_cmdv=%0d n_ack=%0d", n_err, err_lat, n_cmdv, n_ack);
        check("ill05_done", 64'(timed_out), 0);
        check("ill05_n_err", 64'(n_err), 1);
        check("ill05_err_lat", 64'(err_lat), 1);
        check("ill05_n_cmdv", 64'(n_cmdv), 0);
        check("ill05_n_ack", 64'(n_ack), 0);
        run_access(1'b1, 37'h8, 8'h06, 64'h0, 64'h0, 0, 0, 0);
        $display("sel06 n_err=%0d n_cmdv=%0d", n_err, n_cmdv);
        check("ill06_n_err", 64'(n_err), 1);
        check("ill06_n_cmdv", 64'(n_cmdv), 0);
        run_access(1'b0, 37'h8, 8'h00, 64'h0, 64'h0, 0, 0, 0);
        $display("sel00 n_err=%0d n_cmdv=%0d", n_err, n_cmdv);
        check("ill00_n_err", 64'(n_err), 1);
        check("ill00_n_cmdv", 64'(n_cmdv), 0);

        // command backpressure, 2-byte write at lanes 2..3
        run_access(1'b1, 37'h10, 8'h0C, 64'h0000_0000_CAFE_0000, 64'h0, 5, 0, 0);
        $display("wr2  addr=%0h data=%h n_cmdv=%0d stable=%0d ack_lat=%0d", cap_cmd.addr, cap_cmd.data[63:0], n_cmdv, cap_stable, ack_lat);
        check("bp_done", 64'(timed_out), 0);
        check("bp_n_cmdv", 64'(n_cmdv), 6);
        check("bp_stable", 64'(cap_stable), 1);
        check("bp_addr", 64'(cap_cmd.addr), 64'h82);
        check("bp_size", 64'(cap_cmd.size), 64'(e_mem_size_2));
        check("bp_data", cap_cmd.data[63:0], 64'hCAFE);
        check("bp_ack_lat", 64'(ack_lat), 8);

        // cycle abandoned in WAIT
        run_access(1'b0, 37'h20, 8'hFF, 64'h0, 64'h5555_6666_7777_8888, 0, 2, 1);
        $display("drop n_ack=%0d n_yumi=%0d n_err=%0d", n_ack, n_yumi, n_err);
        check("drop_done", 64'(timed_out), 0);
        check("drop_n_ack", 64'(n_ack), 0);
        check("drop_n_yumi", 64'(n_yumi), 1);
        check("drop_n_err", 64'(n_err), 0);

        // 4-byte read, upper half
        run_access(1'b0, 37'h100, 8'hF0, 64'h0, 64'h0000_0000_1122_3344, 0, 1, 0);
        $display("rd4  addr=%0h size=%0d dat_o=%h n_ack=%0d", cap_cmd.addr, cap_cmd.size, dat_r, n_ack);
        check("rd4_done", 64'(timed_out), 0);
        check("rd4_addr", 64'(cap_cmd.addr), 64'h804);
        check("rd4_size", 64'(cap_cmd.size), 64'(e_mem_size_4));
        check("rd4_dat_o", dat_r, 64'h1122_3344_0000_0000);
        check("rd4_n_ack", 64'(n_ack), 1);
        check("rd4_ack_lat", 64'(ack_lat), 4);

`ifdef WB2BP_TIMEOUT_EN
        run_access(1'b0, 37'h30, 8'hFF, 64'h0, 64'h9999_9999_9999_9999, 0, 20, 0);
        $display("tmo  err_lat=%0d n_err=%0d n_ack=%0d n_yumi=%0d", err_lat, n_err, n_ack, n_yumi);
        check("tmo_done", 64'(timed_out), 0);
        check("tmo_err_lat", 64'(err_lat), 18);
        check("tmo_n_err", 64'(n_err), 1);
        check("tmo_n_ack", 64'(n_ack), 0);
        check("tmo_n_yumi", 64'(n_yumi), 1);
        check("tmo_dat_o_hold", dat_r, 64'h1122_3344_0000_0000);
`endif

        // asynchronous reset while in SEND
        we = 1'b0; adr = 37'h44; sel = 8'hFF; dat_w = '0; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        check("ar_send_cmd_v", 64'(mem_cmd_v), 1);
        #2 rst = 1'b1;
        #1;
        $display("areset cmd_v=%0d dat_o=%h ack=%0d err=%0d", mem_cmd_v, dat_r, ack, err);
        check("ar_cmd_v", 64'(mem_cmd_v), 0);
        check("ar_cmd_zero", 64'(|mem_cmd), 0);
        check("ar_dat_o", dat_r, 0);
        check("ar_ack", 64'(ack), 0);
        check("ar_err", 64'(err), 0);
        check("ar_yumi", 64'(mem_resp_yumi), 0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // recovery access after reset
        run_access(1'b0, 37'h0200_0000, 8'h03, 64'h0, 64'h0000_0000_0000_BEEF, 0, 0, 0);
        $display("rd2  addr=%0h dat_o=%h ack_lat=%0d", cap_cmd.addr, dat_r, ack_lat);
        check("rec_done", 64'(timed_out), 0);
        check("rec_addr", 64'(cap_cmd.addr), 64'h1000_0000);
        check("rec_size", 64'(cap_cmd.size), 64'(e_mem_size_2));
        check("rec_dat_o", dat_r, 64'hBEEF);
        check("rec_ack_lat", 64'(ack_lat), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
